// File: rtl/rtype_pkg.sv
// rtype_pkg: shared definitions for the R-type issue stage.
//   - opcode / funct constants for the supported instructions
//   - decoded_t: the decoded form of one instruction word
//   - decode(): instruction word -> decoded_t
package rtype_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_SRL = 6'b000010;

    // uses_rs / uses_rt say whether the operand comes from the register
    // file; when clear, operand A is zero and operand B is the sign-extended
    // immediate.
    typedef struct packed {
        logic [4:0] src_a;
        logic [4:0] src_b;
        logic [4:0] dest;
        logic [4:0] shamt;
        logic [5:0] funct;
        logic       uses_rs;
        logic       uses_rt;
        logic       legal;
    } decoded_t;

    function automatic decoded_t decode(input logic [31:0] w);
        decoded_t d;
        d.src_a   = w[25:21];
        d.src_b   = w[20:16];
        d.dest    = 5'd0;
        d.shamt   = 5'd0;
        d.funct   = 6'd0;
        d.uses_rs = 1'b0;
        d.uses_rt = 1'b0;
        d.legal   = 1'b0;
        if (w[31:26] == OP_RTYPE) begin
            if (w[5:0] == F_ADD || w[5:0] == F_SUB) begin
                d.uses_rs = 1'b1;
                d.uses_rt = 1'b1;
                d.legal   = 1'b1;
                d.dest    = w[15:11];
                d.shamt   = w[10:6];
                d.funct   = w[5:0];
            end else if (w[5:0] == F_SRL) begin
                d.uses_rt = 1'b1;
                d.legal   = 1'b1;
                d.dest    = w[15:11];
                d.shamt   = w[10:6];
                d.funct   = F_SRL;
            end
        end else if (w[31:26] == OP_ADDI) begin
            d.uses_rs = 1'b1;
            d.legal   = 1'b1;
            d.dest    = w[20:16];
            d.funct   = F_ADD;
        end
        return d;
    endfunction

endpackage

// File: rtl/rtype_issue_stage_if.sv
// rtype_issue_stage_if: instruction handshake into the issue stage.
//   instr_valid  producer -> stage  instr holds a valid instruction
//   instr        producer -> stage  32-bit MIPS instruction word
//   instr_ready  stage -> producer  stage accepts instr this cycle
// Handshake: a transfer happens on a rising edge where instr_valid and
// instr_ready are both high; instr must be stable while instr_valid is high,
// and instr_ready may depend combinationally on instr/instr_valid.
interface rtype_issue_stage_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/rtype_regfile.sv
// rtype_regfile: 32 x DATA_W register file.
//   clk, rst          clock, asynchronous active-high reset (clears all)
//   raddr_a/rdata_a   asynchronous read port A
//   raddr_b/rdata_b   asynchronous read port B
//   we/waddr/wdata    synchronous write port
// Register 0 is never written and always reads as zero.
module rtype_regfile #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [4:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [4:0]        waddr,
    input  logic [DATA_W-1:0] wdata
);
    logic [DATA_W-1:0] mem [32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? '0 : mem[raddr_b];
endmodule

// File: rtl/rtype_issue_stage.sv
// rtype_issue_stage: issue/writeback stage in front of a combinational ALU.
// Decodes add/sub/srl/addi, reads the register file, registers operands
// onto alu_*, and writes alu_rd back one cycle later.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_if (slave)         instr_valid / instr_ready / instr handshake
//   stall                 freezes the pipeline while high
//   alu_rs/alu_rt/alu_shamt/alu_funct  registered ALU inputs
//   alu_rd                ALU result for the current alu_* values
//   wb_valid/wb_addr/wb_data  pulse describing the write on the last edge
//   illegal               pulse: an unsupported instruction was consumed
//   retired               completed legal instructions (wraps)
// Build option: define RTYPE_ISSUE_FWD_EN to bypass alu_rd into the operand
// mux; without it a dependent instruction is held off for one cycle.
module rtype_issue_stage
    import rtype_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    rtype_issue_stage_if.slave in_if,
    input  logic               stall,
    output logic [DATA_W-1:0]  alu_rs,
    output logic [DATA_W-1:0]  alu_rt,
    output logic [4:0]         alu_shamt,
    output logic [5:0]         alu_funct,
    input  logic [DATA_W-1:0]  alu_rd,
    output logic               wb_valid,
    output logic [4:0]         wb_addr,
    output logic [DATA_W-1:0]  wb_data,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
);
    decoded_t          dec;
    logic              ex_valid;
    logic [4:0]        ex_dest;
    logic [DATA_W-1:0] rf_a, rf_b;
    logic [DATA_W-1:0] src_a_val, src_b_val;
    logic [DATA_W-1:0] op_a, op_b, imm_ext;
    logic              hazard_a, hazard_b;
    logic              accept, wr_en;

    assign dec     = decode(in_if.instr);
    assign imm_ext = {{(DATA_W-16){in_if.instr[15]}}, in_if.instr[15:0]};

    // The ex-stage instruction writes alu_rd on the next unstalled edge.
    assign wr_en = ex_valid && !stall;

    rtype_regfile #(.DATA_W(DATA_W)) u_rf (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (dec.src_a),
        .rdata_a (rf_a),
        .raddr_b (dec.src_b),
        .rdata_b (rf_b),
        .we      (wr_en),
        .waddr   (ex_dest),
        .wdata   (alu_rd)
    );

    // A source depends on the in-flight result when it names the ex-stage
    // destination; $0 never carries a dependency.
    assign hazard_a = dec.uses_rs && ex_valid && (ex_dest != 5'd0) && (dec.src_a == ex_dest);
    assign hazard_b = dec.uses_rt && ex_valid && (ex_dest != 5'd0) && (dec.src_b == ex_dest);

`ifdef RTYPE_ISSUE_FWD_EN
    assign src_a_val         = hazard_a ? alu_rd : rf_a;
    assign src_b_val         = hazard_b ? alu_rd : rf_b;
    assign in_if.instr_ready = !stall;
`else
    // Hold the dependent instruction for one cycle; by then the result is
    // in the register file and ex_valid has dropped.
    assign src_a_val         = rf_a;
    assign src_b_val         = rf_b;
    assign in_if.instr_ready = !stall && !(in_if.instr_valid && (hazard_a || hazard_b));
`endif

    assign op_a   = dec.uses_rs ? src_a_val : '0;
    assign op_b   = dec.uses_rt ? src_b_val : imm_ext;
    assign accept = in_if.instr_valid && in_if.instr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_dest   <= 5'd0;
            alu_rs    <= '0;
            alu_rt    <= '0;
            alu_shamt <= 5'd0;
            alu_funct <= 6'd0;
            wb_valid  <= 1'b0;
            wb_addr   <= 5'd0;
            wb_data   <= '0;
            illegal   <= 1'b0;
            retired   <= '0;
        end else if (!stall) begin
            ex_valid <= accept && dec.legal;
            illegal  <= accept && !dec.legal;
            if (accept && dec.legal) begin
                alu_rs    <= op_a;
                alu_rt    <= op_b;
                alu_shamt <= dec.shamt;
                alu_funct <= dec.funct;
                ex_dest   <= dec.dest;
            end
            wb_valid <= ex_valid;
            if (ex_valid) begin
                wb_addr <= ex_dest;
                wb_data <= alu_rd;
                retired <= retired + CNT_W'(1);
            end
        end else begin
            // Stalled edge: ex state and counter hold, no write is reported.
            wb_valid <= 1'b0;
            illegal  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rtype_issue_stage.sv
module tb_rtype_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] alu_rs, alu_rt, alu_rd, wb_data;
    logic [4:0]  alu_shamt, wb_addr;
    logic [5:0]  alu_funct;
    logic        wb_valid, illegal;
    logic [15:0] retired;

    rtype_issue_stage_if in_if();

    rtype_issue_stage #(.DATA_W(32), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_if     (in_if),
        .stall     (stall),
        .alu_rs    (alu_rs),
        .alu_rt    (alu_rt),
        .alu_shamt (alu_shamt),
        .alu_funct (alu_funct),
        .alu_rd    (alu_rd),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .illegal   (illegal),
        .retired   (retired)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Bench ALU: add, sub, srl.
    always_comb begin
        case (alu_funct)
            6'b100000: alu_rd = alu_rs + alu_rt;
            6'b100010: alu_rd = alu_rs - alu_rt;
            6'b000010: alu_rd = alu_rt >> alu_shamt;
            default:   alu_rd = 32'd0;
        endcase
    end

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          failures = 0;
    logic [36:0] exp_q[$];        // {dest, value} of each expected write
    logic [31:0] ref_r [32];      // architectural register model
    int          ill_pending = 0;
    int          wb_seen = 0;
    int          legal_acc = 0;
    bit          mon_en = 1'b0;
    bit          rand_stall = 1'b0;
    logic        stall_at_edge = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        ill_pending = 0;
        wb_seen = 0;
        legal_acc = 0;
        for (int i = 0; i < 32; i++) ref_r[i] = 32'd0;
    endtask

    task automatic push_wb(input logic [4:0] dest, input logic [31:0] val);
        exp_q.push_back({dest, val});
        legal_acc++;
        if (dest != 5'd0) ref_r[dest] = val;
    endtask

    // Program-order semantics of one accepted instruction.
    task automatic model_accept(input logic [31:0] w);
        logic [31:0] a, b, imm;
        a   = ref_r[w[25:21]];
        b   = ref_r[w[20:16]];
        imm = {{16{w[15]}}, w[15:0]};
        if (w[31:26] == 6'b000000 && w[5:0] == 6'b100000)      push_wb(w[15:11], a + b);
        else if (w[31:26] == 6'b000000 && w[5:0] == 6'b100010) push_wb(w[15:11], a - b);
        else if (w[31:26] == 6'b000000 && w[5:0] == 6'b000010) push_wb(w[15:11], b >> w[10:6]);
        else if (w[31:26] == 6'b001000)                        push_wb(w[20:16], a + imm);
        else ill_pending++;
    endtask

    always @(posedge clk) stall_at_edge <= stall;

    always @(negedge clk) begin
        logic [36:0] e;
        if (mon_en && !rst) begin
            if (wb_valid) begin
                chk("wb_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("wb_addr", 32'(wb_addr), 32'(e[36:32]));
                    chk("wb_data", wb_data, e[31:0]);
                end
                wb_seen++;
            end
            chk("retired", 32'(retired), 32'(wb_seen[15:0]));
            if (stall_at_edge) chk("wb_in_stall", 32'(wb_valid), 32'd0);
            if (illegal) begin
                chk("illegal_expected", 32'(ill_pending > 0), 32'd1);
                if (ill_pending > 0) ill_pending--;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a falling edge; returns just after the falling edge
    // that follows the accepting rising edge. instr_valid is left high.
    task automatic send(input logic [31:0] w, output int waits);
        in_if.instr_valid = 1'b1;
        in_if.instr = w;
        waits = 0;
        if (rand_stall) stall = ($urandom_range(0, 3) == 0);
        #1;
        while (!in_if.instr_ready && waits < 20) begin
            waits++;
            @(negedge clk);
            if (rand_stall) stall = ($urandom_range(0, 3) == 0);
            #1;
        end
        if (!in_if.instr_ready) chk("accept_timeout", 32'(waits), 32'd0);
        else model_accept(w);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_alu_rs"}, alu_rs, 32'd0);
        chk({tag, "_alu_rt"}, alu_rt, 32'd0);
        chk({tag, "_alu_shamt"}, 32'(alu_shamt), 32'd0);
        chk({tag, "_alu_funct"}, 32'(alu_funct), 32'd0);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, "_wb_addr"}, 32'(wb_addr), 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
        chk({tag, "_illegal"}, 32'(illegal), 32'd0);
        chk({tag, "_retired"}, 32'(retired), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic [4:0]  e_shamt;
        logic [5:0]  e_funct;
        logic        e_ill;
        logic        e_wb;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits;
        int n;
        int nz;
        logic [31:0] w;
        logic [4:0] r1, r2, r3;

        vecs[0] = '{32'h20010007, 32'd0, 32'd7, 5'd0, 6'h20, 1'b0, 1'b1, 5'd1, 32'd7};
        vecs[1] = '{32'h20020003, 32'd0, 32'd3, 5'd0, 6'h20, 1'b0, 1'b1, 5'd2, 32'd3};
        vecs[2] = '{32'h00221820, 32'd7, 32'd3, 5'd0, 6'h20, 1'b0, 1'b1, 5'd3, 32'd10};
        vecs[3] = '{32'h00221822, 32'd7, 32'd3, 5'd0, 6'h22, 1'b0, 1'b1, 5'd3, 32'd4};
        vecs[4] = '{32'h00022042, 32'd0, 32'd3, 5'd1, 6'h02, 1'b0, 1'b1, 5'd4, 32'd1};
        vecs[5] = '{32'h8C010000, 32'd0, 32'd3, 5'd1, 6'h02, 1'b1, 1'b0, 5'd0, 32'd0};
        vecs[6] = '{32'h20000005, 32'd0, 32'd5, 5'd0, 6'h20, 1'b0, 1'b1, 5'd0, 32'd5};
        vecs[7] = '{32'h00642820, 32'd4, 32'd1, 5'd0, 6'h20, 1'b0, 1'b1, 5'd5, 32'd5};
        vecs[8] = '{32'h00003020, 32'd0, 32'd0, 5'd0, 6'h20, 1'b0, 1'b1, 5'd6, 32'd0};
        vecs[9] = '{32'h2021FFFF, 32'd7, 32'hFFFFFFFF, 5'd0, 6'h20, 1'b0, 1'b1, 5'd1, 32'd6};

        // ---- reset ----
        model_reset();
        rst = 1'b1;
        stall = 1'b0;
        in_if.instr_valid = 1'b0;
        in_if.instr = 32'd0;
        #1;
        check_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // ---- table: load, add, sub, srl, illegal, $0 ----
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].instr, waits);
            in_if.instr_valid = 1'b0;
            chk($sformatf("v%0d_alu_rs", i), alu_rs, vecs[i].e_rs);
            chk($sformatf("v%0d_alu_rt", i), alu_rt, vecs[i].e_rt);
            chk($sformatf("v%0d_alu_shamt", i), 32'(alu_shamt), 32'(vecs[i].e_shamt));
            chk($sformatf("v%0d_alu_funct", i), 32'(alu_funct), 32'(vecs[i].e_funct));
            chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(vecs[i].e_ill));
            @(negedge clk);
            chk($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'(vecs[i].e_wb));
            if (vecs[i].e_wb) begin
                chk($sformatf("v%0d_wb_addr", i), 32'(wb_addr), 32'(vecs[i].e_addr));
                chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].e_data);
            end
        end
        chk("retired_table", 32'(retired), 32'd9);

        // ---- back-to-back RAW hazard ----
        send(32'h20010007, waits);
        send(32'h00211820, waits);
        in_if.instr_valid = 1'b0;
`ifdef RTYPE_ISSUE_FWD_EN
        chk("haz_ready_low_cycles", 32'(waits), 32'd0);
`else
        chk("haz_ready_low_cycles", 32'(waits), 32'd1);
`endif
        n = 0;
        while (!(wb_valid && wb_addr == 5'd3) && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("haz_wb_delay", 32'(n), 32'd1);
        chk("haz_wb_data", wb_data, 32'd14);

        // ---- stall for three cycles with add $7,$1,$1 in ex ----
        send(32'h00213820, waits);
        in_if.instr_valid = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_alu_rs", i), alu_rs, 32'd7);
            chk($sformatf("stall%0d_alu_rt", i), alu_rt, 32'd7);
            chk($sformatf("stall%0d_wb_valid", i), 32'(wb_valid), 32'd0);
            chk($sformatf("stall%0d_ready", i), 32'(in_if.instr_ready), 32'd0);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("stall_wb_valid", 32'(wb_valid), 32'd1);
        chk("stall_wb_addr", 32'(wb_addr), 32'd7);
        chk("stall_wb_data", wb_data, 32'd14);
        @(negedge clk);
        chk("stall_single_write", 32'(wb_valid), 32'd0);

        // ---- reset while an add is in ex ----
        send(32'h00213820, waits);
        in_if.instr_valid = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_zero("midrst");
        nz = 0;
        for (int i = 1; i < 32; i++) if (dut.u_rf.mem[i] != 32'd0) nz++;
        chk("midrst_rf_cleared", 32'(nz), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("postrst%0d_wb_valid", i), 32'(wb_valid), 32'd0);
            @(negedge clk);
        end

        // ---- randomized stream against the reference model ----
        rand_stall = 1'b1;
        for (int k = 0; k < 300; k++) begin
            r1 = 5'($urandom_range(0, 7));
            r2 = 5'($urandom_range(0, 7));
            r3 = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0, 1, 2: w = {6'b001000, r1, r2, 16'($urandom)};
                3, 4:    w = {6'b000000, r1, r2, r3, 5'($urandom_range(0, 31)), 6'b100000};
                5:       w = {6'b000000, r1, r2, r3, 5'($urandom_range(0, 31)), 6'b100010};
                6, 7:    w = {6'b000000, r1, r2, r3, 5'($urandom_range(0, 31)), 6'b000010};
                8:       w = {6'b100011, r1, r2, 16'($urandom)};
                default: w = {6'b000000, r1, r2, r3, 5'd0, 6'b100100};
            endcase
            send(w, waits);
            if ($urandom_range(0, 1) == 0) begin
                in_if.instr_valid = 1'b0;
                n = $urandom_range(0, 2);
                for (int j = 0; j < n; j++) begin
                    stall = ($urandom_range(0, 3) == 0);
                    @(negedge clk);
                end
            end
        end
        rand_stall = 1'b0;
        in_if.instr_valid = 1'b0;
        stall = 1'b0;
        repeat (6) @(negedge clk);
        chk("drain_exp_q", 32'(exp_q.size()), 32'd0);
        chk("drain_illegal", 32'(ill_pending), 32'd0);
        chk("retired_final", 32'(retired), 32'(legal_acc[15:0]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtype_issue_stage.md
Name: rtype_issue_stage

Overview:
- Issue/writeback stage that sits directly upstream of the combinational `alu`.
- Accepts MIPS instruction words over a valid/ready handshake and decodes R-type (add/sub/srl) and addi.
- Reads a 32x32 register file, presents registered rs/rt/shamt/funct operands to the ALU, then writes the ALU's rd result back.
- Provides a two-cycle issue->writeback pipeline with RAW-hazard handling and a retired-instruction counter.

Parameters:
- DATA_W, 32, operand/register width; must match the ALU.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instr holds a valid instruction this cycle.
- instr_ready  out  1  stage accepts instr this cycle.
- instr  in  32  instruction word.
- stall  in  1  freezes the whole pipeline while high.
- alu_rs  out  DATA_W  ALU operand A (registered).
- alu_rt  out  DATA_W  ALU operand B (registered).
- alu_shamt  out  5  shift amount (registered).
- alu_funct  out  6  ALU function code (registered).
- alu_rd  in  DATA_W  combinational ALU result for the current alu_* outputs.
- wb_valid  out  1  one-cycle pulse; a register write happened on the previous edge.
- wb_addr  out  5  destination register of that write.
- wb_data  out  DATA_W  value written.
- illegal  out  1  one-cycle pulse; an unsupported instruction was consumed.
- retired  out  CNT_W  count of completed legal instructions.

Behaviour:
- Reset (async, immediate): all 32 registers cleared, ex_valid=0, alu_*=0, wb_valid=0, wb_addr=0, wb_data=0, illegal=0, retired=0.
- Accept rule: transfer occurs when instr_valid && instr_ready. instr_ready = !stall, and also gated by the interlock when forwarding is compiled out.
- Decode of an accepted instr (opcode = instr[31:26]):
  - opcode 000000, funct 100000/100010 (add/sub): alu_rs=R[rs], alu_rt=R[rt], alu_shamt=instr[10:6], alu_funct=funct, dest=rd field.
  - opcode 000000, funct 000010 (srl): alu_rs=0, alu_rt=R[rt], alu_shamt=instr[10:6], alu_funct=000010, dest=rd field.
  - opcode 001000 (addi): alu_rs=R[rs], alu_rt=sign-extended instr[15:0], alu_shamt=0, alu_funct=100000, dest=rt field.
  - Anything else: consumed, not issued; ex_valid=0 next cycle; illegal pulses 1 in the next cycle.
- Latency: an instruction accepted at edge N drives alu_* from N to N+1. The register file is written from alu_rd at edge N+1. wb_valid/wb_addr/wb_data are visible during N+1..N+2, and retired increments at edge N+1.
- No accepted instruction at edge N: ex_valid=0; alu_* hold their last values; no write occurs.
- Destination $0: the write is suppressed and R[0] is always reads-as-zero. wb_valid still pulses with wb_addr=0 and wb_data=alu_rd, and retired still increments.
- RAW hazard: an incoming source equals the ex-stage dest, ex_valid=1, dest!=0. With forwarding, alu_rd is bypassed into the operand mux. Same-cycle register read and write returns the new value.
- Stall: holds ex registers, write enable and counter, with no duplicate write. wb_valid is 0 during stall cycles.
- retired wraps modulo 2^CNT_W.
- Reset mid-operation discards the in-flight instruction; no write occurs.

Optional Feature:
- Macro: RTYPE_ISSUE_FWD_EN.
- Defined: bypass as described; instr_ready = !stall; back-to-back dependent instructions run at full rate.
- Undefined: no bypass path. When an instr_valid instruction hazards on the ex-stage dest, instr_ready=0 for exactly one cycle. The instruction is accepted the next cycle and reads the written value from the register file.

Decomposition:
- Package rtype_pkg holds:
  - opcode constants: OP_RTYPE=6'b000000, OP_ADDI=6'b001000.
  - funct constants: F_ADD=6'b100000, F_SUB=6'b100010, F_SRL=6'b000010.
  - decoded-instruction struct typedef: src_a, src_b, dest, shamt, funct, uses_rs, uses_rt, legal.
- One sub-module, rtype_regfile: 32xDATA_W, two async read ports, one sync write port, $0 hardwired zero, async reset clears all entries.

Test Plan:
- Load, add and sub (stall=0, bench's alu connected; instruction sequence separated by one idle cycle each):
  - 0x20010007 (addi $1,$0,7)
  - 0x20020003 (addi $2,$0,3)
  - 0x00221820 (add $3,$1,$2)
  - 0x00221822 (sub $3,$1,$2)
  - -> wb_data sequence 7, 3, 10, 4; wb_addr 1, 2, 3, 3; retired=4.
- srl: after the load of $2=3, issue 0x00022042 (srl $4,$2,1) -> alu_rs=0, alu_rt=3, alu_shamt=1, alu_funct=000010; wb_addr=4, wb_data=1.
- Back-to-back hazard: 0x20010007 then 0x00211820 (add $3,$1,$1) in consecutive cycles:
  - FWD_EN -> wb_data=14 one cycle after the addi writeback, instr_ready never low.
  - Without FWD_EN -> instr_ready low exactly one cycle, wb_data=14.
- Illegal: 0x8C010000 (lw) -> illegal=1 for one cycle, no wb_valid, retired unchanged; the following legal instruction proceeds normally.
- $0 and stall:
  - 0x20000005 (addi $0,$0,5) -> wb_addr=0, R[0] still reads 0.
  - Assert stall 3 cycles mid-stream -> alu_* frozen, single write only.
- Reset mid-flight: assert rst while an add is in ex -> all outputs 0 immediately, R[1..31]=0, no wb_valid after release.
